pe_mac_stream: RTL and testbench

- Next-generation systolic processing element for the block-based matrix-multiply array. It replaces the free-running MAC PE.
- Adds per-direction valid tags, explicit first/last accumulation framing, a full-precision guarded accumulator, selectable rounding, sticky saturation/protocol flags and a global stall.
- Tiled N×N in the array. West and north operands pass through with one-cycle latency; each finished dot-product tile is emitted as a result pulse.

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_round_sat.sv | 42 ++++
 rtl/pe_mac_stream.sv | 127 ++++++++++++
 tb/tb_pe_mac_stream.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and width helpers for the streaming MAC processing element.
package pe_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;

    // Helpers build their bound in a wide word; callers size-cast it to their own width.
    localparam int MAX_W = 128;

    function automatic int acc_width(int bit_width, int guard_bits);
        return 2 * bit_width + guard_bits;
    endfunction

    function automatic logic [MAX_W-1:0] smax(int w);
        return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] smin(int w);
        return ~smax(w);
    endfunction

endpackage

// File: rtl/pe_round_sat.sv
// Rescales a full-precision accumulator to the result format: optional half-up
// rounding, arithmetic shift by FRAC_WIDTH, then clip to the signed result range.
module pe_round_sat
    import pe_pkg::*;
#(
    parameter int ACC_W      = 40,
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int ROUND_MODE = ROUND_TRUNC
) (
    input  logic [ACC_W-1:0]     acc,
    output logic [BIT_WIDTH-1:0] value,
    output logic                 sat
);

    // One extra bit so the rounding bias can never wrap the top of the range.
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] RND_BIAS =
        (ROUND_MODE == ROUND_HALF_UP) ? (EXT_W'(1) << (FRAC_WIDTH - 1)) : '0;
    localparam logic signed [EXT_W-1:0] RES_MAX = EXT_W'(smax(BIT_WIDTH));
    localparam logic signed [EXT_W-1:0] RES_MIN = EXT_W'(smin(BIT_WIDTH));

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        biased  = $signed({acc[ACC_W-1], acc}) + RND_BIAS;
        shifted = biased >>> FRAC_WIDTH;
        value   = shifted[BIT_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > RES_MAX) begin
            value = RES_MAX[BIT_WIDTH-1:0];
            sat   = 1'b1;
        end else if (shifted < RES_MIN) begin
            value = RES_MIN[BIT_WIDTH-1:0];
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/pe_mac_stream.sv
// Systolic PE: registered west/north pass-through plus a framed, guarded,
// saturating multiply-accumulate that emits one rescaled result per tile.
module pe_mac_stream
    import pe_pkg::*;
#(
    parameter int BIT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int GUARD_BITS = 8,
    parameter int ROUND_MODE = ROUND_TRUNC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [BIT_WIDTH-1:0] data_west,
    input  logic                 valid_west,
    input  logic                 first_west,
    input  logic                 last_west,
    input  logic [BIT_WIDTH-1:0] data_north,
    input  logic                 valid_north,
    output logic [BIT_WIDTH-1:0] data_east,
    output logic                 valid_east,
    output logic                 first_east,
    output logic                 last_east,
    output logic [BIT_WIDTH-1:0] data_south,
    output logic                 valid_south,
    output logic [BIT_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 sat_flag,
    output logic                 err_flag
);

    localparam int ACC_W  = acc_width(BIT_WIDTH, GUARD_BITS);
    localparam int PROD_W = 2 * BIT_WIDTH;
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'(smax(ACC_W));
    localparam logic signed [SUM_W-1:0] ACC_MIN = SUM_W'(smin(ACC_W));

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum;
    logic                     acc_sat;
    logic                     fire;
    logic                     mismatch;
    logic [BIT_WIDTH-1:0]     rs_value;
    logic                     rs_sat;

    assign fire     = valid_west & valid_north;
    assign mismatch = valid_west ^ valid_north;

    always_comb begin
        prod     = $signed(data_west) * $signed(data_north);
        acc_base = first_west ? '0 : acc;
        sum      = SUM_W'(prod) + SUM_W'(acc_base);
        acc_next = sum[ACC_W-1:0];
        acc_sat  = 1'b0;
        if (sum > ACC_MAX) begin
            acc_next = ACC_MAX[ACC_W-1:0];
            acc_sat  = 1'b1;
        end else if (sum < ACC_MIN) begin
            acc_next = ACC_MIN[ACC_W-1:0];
            acc_sat  = 1'b1;
        end
    end

    pe_round_sat #(
        .ACC_W      (ACC_W),
        .BIT_WIDTH  (BIT_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH),
        .ROUND_MODE (ROUND_MODE)
    ) u_round_sat (
        .acc   (acc_next),
        .value (rs_value),
        .sat   (rs_sat)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: acc is reset along with the outputs so a reset mid-tile cannot leak a stale partial sum.
            acc          <= '0;
            data_east    <= '0;
            valid_east   <= 1'b0;
            first_east   <= 1'b0;
            last_east    <= 1'b0;
            data_south   <= '0;
            valid_south  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            sat_flag     <= 1'b0;
            err_flag     <= 1'b0;
        end else if (en) begin
            if (clr) begin
                acc          <= '0;
                result_valid <= 1'b0;
                valid_east   <= 1'b0;
                valid_south  <= 1'b0;
                sat_flag     <= 1'b0;
                err_flag     <= 1'b0;
            end else begin
                data_east    <= data_west;
                valid_east   <= valid_west;
                first_east   <= first_west;
                last_east    <= last_west;
                data_south   <= data_north;
                valid_south  <= valid_north;
                result_valid <= 1'b0;
                if (mismatch) err_flag <= 1'b1;
                if (fire) begin
                    if (acc_sat) sat_flag <= 1'b1;
                    if (last_west) begin
                        result       <= rs_value;
                        result_valid <= 1'b1;
                        acc          <= '0;
                        if (rs_sat) sat_flag <= 1'b1;
                    end else begin
                        acc <= acc_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed bench for pe_mac_stream: truncating and half-up instances share stimulus;
// a reference model queues expected tile results that are popped on each result pulse.
module tb_pe_mac_stream;

    logic        clk = 1'b0;
    logic        rst_n, en, clr;
    logic [15:0] data_west, data_north;
    logic        valid_west, first_west, last_west, valid_north;

    logic [15:0] data_east0, data_south0, result0;
    logic        valid_east0, first_east0, last_east0, valid_south0, rv0, sat0, err0;
    logic [15:0] data_east1, data_south1, result1;
    logic        valid_east1, first_east1, last_east1, valid_south1, rv1, sat1, err1;

    typedef struct {
        logic [15:0] r0;
        logic [15:0] r1;
    } exp_t;

    exp_t   exp_q[$];
    longint macc;
    int     checks = 0;
    int     errors = 0;

    localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
    localparam longint ACC_MIN = -(64'sd1 <<< 39);

    always #5 clk = ~clk;

    pe_mac_stream #(.ROUND_MODE(0)) u_trunc (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .data_west(data_west), .valid_west(valid_west), .first_west(first_west),
        .last_west(last_west), .data_north(data_north), .valid_north(valid_north),
        .data_east(data_east0), .valid_east(valid_east0), .first_east(first_east0),
        .last_east(last_east0), .data_south(data_south0), .valid_south(valid_south0),
        .result(result0), .result_valid(rv0), .sat_flag(sat0), .err_flag(err0)
    );

    pe_mac_stream #(.ROUND_MODE(1)) u_half_up (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .data_west(data_west), .valid_west(valid_west), .first_west(first_west),
        .last_west(last_west), .data_north(data_north), .valid_north(valid_north),
        .data_east(data_east1), .valid_east(valid_east1), .first_east(first_east1),
        .last_east(last_east1), .data_south(data_south1), .valid_south(valid_south1),
        .result(result1), .result_valid(rv1), .sat_flag(sat1), .err_flag(err1)
    );

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] rescale(longint s, int half_up);
        longint v;
        v = (s + (half_up != 0 ? 64'sd128 : 64'sd0)) >>> 8;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    task automatic model_beat(logic [15:0] dw, logic [15:0] dn, logic f, logic l);
        longint p, s;
        exp_t   e;
        p = longint'($signed(dw)) * longint'($signed(dn));
        s = (f ? 64'sd0 : macc) + p;
        if (s > ACC_MAX) s = ACC_MAX;
        if (s < ACC_MIN) s = ACC_MIN;
        if (l) begin
            e.r0 = rescale(s, 0);
            e.r1 = rescale(s, 1);
            exp_q.push_back(e);
            macc = 0;
        end else begin
            macc = s;
        end
    endtask

    // One clock edge, then score any result pulse the edge produced.
    task automatic tick();
        logic en_s;
        exp_t e;
        en_s = en;
        @(posedge clk);
        #1;
        check("pulse_align", rv1, rv0);
        if (en_s && rst_n && rv0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result_trunc", result0, e.r0);
                check("result_half_up", result1, e.r1);
            end
        end
    endtask

    task automatic drive(logic vw, logic vn, logic [15:0] dw, logic [15:0] dn, logic f, logic l);
        valid_west  = vw;
        valid_north = vn;
        data_west   = dw;
        data_north  = dn;
        first_west  = f;
        last_west   = l;
        if (en && !clr && vw && vn) model_beat(dw, dn, f, l);
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle();
        clr  = 1'b0;
        macc = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; macc = 0;
        valid_west = 1'b0; valid_north = 1'b0; first_west = 1'b0; last_west = 1'b0;
        data_west = 16'h1234; data_north = 16'h5678;
        #12;
        check("reset_data_east", data_east0, 16'h0000);
        check("reset_result", result0, 16'h0000);
        check("reset_flags", {rv0, sat0, err0, valid_east0, valid_south0}, 5'b0);
        rst_n = 1'b1;

        // Single-beat tile: 1.5 * 2.0
        drive(1, 1, 16'h0180, 16'h0200, 1, 1);
        check("east_data", data_east0, 16'h0180);
        check("south_data", data_south0, 16'h0200);
        check("east_tags", {valid_east0, first_east0, last_east0, valid_south0}, 4'b1111);
        idle();
        check("pulse_one_cycle", rv0, 1'b0);
        check("east_valid_drop", valid_east0, 1'b0);

        // Three-beat tile: no pulse until the last beat
        drive(1, 1, 16'h0100, 16'h0100, 1, 0);
        check("no_pulse_beat1", rv0, 1'b0);
        drive(1, 1, 16'h0080, 16'h0080, 0, 0);
        check("no_pulse_beat2", rv0, 1'b0);
        drive(1, 1, 16'hFF00, 16'h0040, 0, 1);
        check("pulse_beat3", rv0, 1'b1);
        idle();

        // Result saturation, sticky until clr
        check("sat_clear_before", sat0, 1'b0);
        drive(1, 1, 16'h7F00, 16'h0200, 1, 1);
        check("sat_pos", sat0, 1'b1);
        idle();
        idle();
        check("sat_sticky", sat0, 1'b1);
        drive(1, 1, 16'h8100, 16'h0200, 1, 1);
        check("sat_neg", sat0, 1'b1);
        do_clr();
        check("clr_sat", sat0, 1'b0);
        check("clr_result_holds", result0, 16'h8000);

        // Rounding: 1/512 -> 0 truncated, 1 half-up
        drive(1, 1, 16'h0001, 16'h0080, 1, 1);
        check("round_no_sat", {sat0, sat1}, 2'b00);
        idle();

        // Protocol error: lone west valid must not touch acc
        drive(1, 1, 16'h0100, 16'h0100, 1, 0);
        drive(1, 0, 16'h4000, 16'h4000, 0, 0);
        check("err_set", err0, 1'b1);
        check("err_passthru", data_east0, 16'h4000);
        drive(1, 1, 16'h0100, 16'h0100, 0, 1);
        check("err_sticky", err0, 1'b1);
        do_clr();
        check("clr_err", err0, 1'b0);

        // Stall mid-tile with active-looking inputs, then stall during a pulse
        drive(1, 1, 16'h0200, 16'h0100, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 1, 16'h7777, 16'h3333, 1, 1);
        check("stall_east_frozen", data_east0, 16'h0200);
        check("stall_valid_frozen", {valid_east0, first_east0, last_east0}, 3'b110);
        check("stall_no_pulse", rv0, 1'b0);
        en = 1'b1;
        drive(1, 1, 16'h0100, 16'h0100, 0, 1);
        en = 1'b0;
        idle();
        idle();
        check("stall_pulse_held", rv0, 1'b1);
        check("stall_result_held", result0, 16'h0300);
        en = 1'b1;
        idle();
        check("pulse_released", rv0, 1'b0);

        // Async reset between edges discards the partial sum
        drive(1, 1, 16'h0100, 16'h0100, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_east", data_east0, 16'h0000);
        check("arst_result", result0, 16'h0000);
        check("arst_flags", {rv0, sat0, err0, valid_east0, valid_south0, first_east0}, 6'b0);
        macc = 0;
        #1;
        rst_n = 1'b1;
        drive(1, 1, 16'h0100, 16'h0200, 0, 1);
        idle();

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
